// File: rtl/stop_it_multi_if.sv
// stop_it_multi_if: game controller buttons/switches in, score/count/target display out.
interface stop_it_multi_if #(
  parameter int CNT_W = 5,
  parameter int NUM_LEDS = 16
);
  logic go, stop, load;
  logic [1:0] speed;
  logic [NUM_LEDS-1:0] switches, leds;
  logic [CNT_W-1:0] count, target;
  logic count_en, target_en, won;
  logic [2:0] state;
  modport master(output go, stop, load, speed, switches,
                 input leds, count, count_en, target, target_en, state, won);
  modport slave(input go, stop, load, speed, switches,
                output leds, count, count_en, target, target_en, state, won);
endinterface

// File: rtl/stop_it_multi.sv
// stop_it_multi: parametrised stop-it game controller; define STOP_IT_LIVES_EN so a wrong stop
// costs one score LED.
module stop_it_multi #(
  parameter int CNT_W = 5,
  parameter int NUM_LEDS = 16,
  parameter int START_TICKS = 8,
  parameter int FLASH_TICKS = 16,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input logic clk_i,
  input logic rst_i,
  stop_it_multi_if.slave bus
);
  typedef enum logic [2:0] {IDLE, START, RUN, WRONG, CORRECT, WON} state_t;
  localparam logic [15:0] START_LAST = 16'(START_TICKS - 1);
  localparam logic [15:0] FLASH_LAST = 16'(FLASH_TICKS - 1);
  state_t state, nx;
  logic [15:0] tick, lfsr;
  logic [1:0] pcnt, speed;
  logic [CNT_W-1:0] count, target;
  logic [NUM_LEDS-1:0] score, score_nx, shifted;
  logic last, dec;
  assign shifted = {score[NUM_LEDS-2:0], 1'b1};
  assign last = tick == FLASH_LAST;
  // a stop in the same cycle as a due decrement wins, so the judged value stays on display
  assign dec = state == RUN && !bus.stop && pcnt == speed;
  always_comb begin
    nx = state;
    score_nx = score;
    case (state)
      IDLE: begin
        if (bus.load) score_nx = bus.switches;
        if (bus.go) nx = START;
      end
      START: if (tick == START_LAST) nx = RUN;
      RUN: if (bus.stop) nx = count == target ? CORRECT : WRONG;
      WRONG: if (last) begin
        nx = IDLE;
`ifdef STOP_IT_LIVES_EN
        score_nx = score >> 1;
`else
        score_nx = score;
`endif
      end
      CORRECT: if (last) begin
        nx = &shifted ? WON : IDLE;
        score_nx = shifted;
      end
      WON: if (bus.go) begin
        nx = IDLE;
        score_nx = '0;
      end
      default: nx = IDLE;
    endcase
  end
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      state <= IDLE;
      tick <= '0;
      lfsr <= LFSR_SEED;
      pcnt <= '0;
      speed <= '0;
      count <= '1;
      target <= '0;
      score <= '0;
    end else begin
      state <= nx;
      score <= score_nx;
      tick <= nx != state ? '0 : tick + 16'd1;
      pcnt <= (nx != state || dec) ? '0 : pcnt + 2'd1;
      count <= nx == IDLE ? '1 : dec ? count - 1'b1 : count;
      if (state == IDLE) lfsr <= {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
      if (state == IDLE && bus.go) begin
        target <= lfsr[CNT_W-1:0];
        speed <= bus.speed;
      end
    end
  assign bus.state = state;
  assign bus.won = state == WON;
  assign bus.leds = state == WON ? {NUM_LEDS{~tick[0]}} : score;
  assign bus.count = count;
  assign bus.target = target;
  assign bus.count_en = (state == WRONG || state == CORRECT) ? ~tick[0] : 1'b1;
  assign bus.target_en = state == IDLE ? 1'b0 : state == WRONG ? tick[0] :
                         state == CORRECT ? ~tick[0] : 1'b1;
endmodule

// File: tb/tb_stop_it_multi.sv
// tb_stop_it_multi: randomized rounds checked against a time-since-entry reference model.
module tb_stop_it_multi;
  localparam int CNT_W = 5, NUM_LEDS = 16, START_TICKS = 8, FLASH_TICKS = 16;
  localparam logic [15:0] SEED = 16'hACE1;
  logic clk = 1'b0, rst = 1'b1;
  always #5 clk = ~clk;
  stop_it_multi_if #(.CNT_W(CNT_W), .NUM_LEDS(NUM_LEDS)) bus();
  stop_it_multi #(.CNT_W(CNT_W), .NUM_LEDS(NUM_LEDS), .START_TICKS(START_TICKS),
                  .FLASH_TICKS(FLASH_TICKS), .LFSR_SEED(SEED))
    dut (.clk_i(clk), .rst_i(rst), .bus(bus));
  int n_chk = 0, n_fail = 0;
  int m_state, m_age, m_spd, m_frozen;
  logic [15:0] m_score, m_lfsr;
  logic [CNT_W-1:0] m_target;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int cur_count();
    int m = 1 << CNT_W;
    return (((m - 1) - m_age / (m_spd + 1)) % m + m) % m;
  endfunction

  function automatic logic [15:0] lfsr_next(input logic [15:0] x);
    return (x >> 1) ^ (x[0] ? 16'hB400 : 16'h0000);
  endfunction

  task automatic model_reset();
    m_state = 0; m_age = 0; m_spd = 0; m_frozen = (1 << CNT_W) - 1;
    m_score = '0; m_lfsr = SEED; m_target = '0;
  endtask

  task automatic model_step(input logic go, stop, load, input logic [1:0] sp, input logic [15:0] sw);
    int nxt = m_state;
    case (m_state)
      0: begin
        if (load) m_score = sw;
        if (go) begin m_target = m_lfsr[CNT_W-1:0]; m_spd = int'(sp); nxt = 1; end
        m_lfsr = lfsr_next(m_lfsr);
      end
      1: if (m_age + 1 == START_TICKS) nxt = 2;
      2: if (stop) begin
        m_frozen = cur_count();
        nxt = (m_frozen == int'(m_target)) ? 4 : 3;
      end
      3: if (m_age + 1 == FLASH_TICKS) begin
        nxt = 0;
`ifdef STOP_IT_LIVES_EN
        m_score = m_score >> 1;
`endif
      end
      4: if (m_age + 1 == FLASH_TICKS) begin
        m_score = {m_score[NUM_LEDS-2:0], 1'b1};
        nxt = (m_score == 16'hFFFF) ? 5 : 0;
      end
      5: if (go) begin m_score = '0; nxt = 0; end
      default: nxt = 0;
    endcase
    m_age = (nxt != m_state) ? 0 : m_age + 1;
    m_state = nxt;
  endtask

  task automatic check_outputs();
    bit odd = (m_age % 2) == 1;
    int ec = (m_state <= 1) ? (1 << CNT_W) - 1 : (m_state == 2) ? cur_count() : m_frozen;
    chk("state", 32'(bus.state), 32'(m_state));
    chk("leds", 32'(bus.leds), m_state == 5 ? (odd ? 32'h0 : 32'hFFFF) : 32'(m_score));
    chk("count", 32'(bus.count), 32'(ec));
    chk("target", 32'(bus.target), 32'(m_target));
    chk("count_en", 32'(bus.count_en), (m_state == 3 || m_state == 4) ? 32'(!odd) : 32'h1);
    chk("target_en", 32'(bus.target_en), m_state == 0 ? 32'h0 : m_state == 3 ? 32'(odd) :
        m_state == 4 ? 32'(!odd) : 32'h1);
    chk("won", 32'(bus.won), 32'(m_state == 5));
  endtask

  task automatic cyc(input logic go, stop, load, input logic [1:0] sp, input logic [15:0] sw);
    bus.go = go; bus.stop = stop; bus.load = load; bus.speed = sp; bus.switches = sw;
    @(posedge clk);
    model_step(go, stop, load, sp, sw);
    #1 check_outputs();
  endtask

  function automatic bit want_stop(input int mode);
    int c = cur_count();
    if (mode == 0) return c == int'(m_target);
    if (mode == 1) return c != int'(m_target) && ($urandom % 4 == 0);
    return (m_age % (m_spd + 1)) == m_spd;
  endfunction

  task automatic play(input logic [1:0] spd, input int mode, input logic [15:0] pre, input logic do_load);
    int n = 0;
    int judged;
    cyc(1'b1, 1'b0, do_load, spd, pre);
    while (n < 400 && !(m_state == 2 && want_stop(mode))) begin
      cyc(1'($urandom), m_state == 1 && 1'($urandom), 1'($urandom), 2'($urandom), 16'($urandom));
      n++;
    end
    chk("run_wait", 32'(n < 400), 32'h1);
    judged = cur_count();
    cyc(1'b0, 1'b1, 1'b0, spd, 16'h0);
    chk("judged", 32'(bus.count), 32'(judged));
    n = 0;
    while (n < 64 && (m_state == 3 || m_state == 4)) begin
      cyc(1'($urandom), 1'($urandom), 1'($urandom), 2'($urandom), 16'($urandom));
      n++;
    end
    chk("flash_wait", 32'(n < 64), 32'h1);
    if (m_state == 5) begin
      repeat (2 + $urandom % 5) cyc(1'b0, 1'($urandom), 1'($urandom), 2'($urandom), 16'($urandom));
      cyc(1'b1, 1'b0, 1'b0, 2'd0, 16'h0);
      chk("won_exit_leds", 32'(bus.leds), 32'h0);
    end
  endtask

  initial begin
    bus.go = 0; bus.stop = 0; bus.load = 0; bus.speed = '0; bus.switches = '0;
    repeat (2) @(posedge clk);
    #1 model_reset();
    check_outputs();
    rst = 1'b0;
    play(2'd2, 0, 16'h0000, 1'b0);
    chk("first_win_score", 32'(bus.leds), 32'h1);
    play(2'd0, 0, 16'h7FFF, 1'b1);
    play(2'd1, 1, 16'h0007, 1'b1);
`ifdef STOP_IT_LIVES_EN
    chk("lives_score", 32'(bus.leds), 32'h3);
`else
    chk("lives_score", 32'(bus.leds), 32'h7);
`endif
    play(2'd2, 2, 16'h0000, 1'b0);
    for (int r = 0; r < 25; r++) begin
      repeat ($urandom % 5) cyc(1'b0, 1'($urandom), 1'($urandom), 2'($urandom), 16'($urandom));
      play(2'($urandom), int'($urandom % 3), 16'($urandom), 1'($urandom));
    end
    cyc(1'b1, 1'b0, 1'b1, 2'd3, 16'h00FF);
    repeat (12) cyc(1'b0, 1'b0, 1'b0, 2'd3, 16'h0);
    #2 rst = 1'b1;
    #1 model_reset();
    chk("rst_state", 32'(bus.state), 32'h0);
    chk("rst_leds", 32'(bus.leds), 32'h0);
    chk("rst_count", 32'(bus.count), 32'h1F);
    chk("rst_target_en", 32'(bus.target_en), 32'h0);
    check_outputs();
    @(posedge clk);
    #1 rst = 1'b0;
    check_outputs();
    play(2'd1, 0, 16'h0000, 1'b0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
